lcu_seq_chunked: RTL and testbench
==================================

// Module: lcu_seq_chunked
// PURPOSE
//  Multi-cycle lookahead-carry unit: the consumer side of the P/G vectors
//  that the comparison decomposition drives into an $lcu.
//  Resolves CO[i] = G[i] | (P[i] & CO[i-1]), with CO[-1] = CI, CHUNK bits
//  per clock.
//  Used where a wide carry resolution must be time-multiplexed over a
//  narrow carry resource instead of one wide combinational chain.
//  Valid/ready handshake on the input and output sides; one operation in
//  flight.
// PARAMETERS
//  WIDTH  8  width of P, G, CO; >= 1
//  CHUNK  2  bits resolved per RUN cycle; 1 <= CHUNK <= WIDTH
// PORTS
//  CLK        in   1      clock, all state updates on rising edge
//  SRST       in   1      synchronous reset, active-high
//  IN_VALID   in   1      P/G/CI are valid
//  IN_READY   out  1      block accepts an operation (IDLE only)
//  P          in   WIDTH  propagate vector
//  G          in   WIDTH  generate vector
//  CI         in   1      carry-in
//  OUT_VALID  out  1      CO valid (DONE only)
//  OUT_READY  in   1      consumer takes CO
//  CO         out  WIDTH  carry-out vector
// BEHAVIOUR
//  - Reset (SRST=1 at an edge): state=IDLE, IN_READY=1, OUT_VALID=0, CO=0,
//    index=0, carry=0. Reset mid-RUN or mid-DONE aborts the operation; no
//    partial result is ever presented.
//  - FSM states and transitions:
//    - IDLE: IN_READY=1. On IN_VALID&IN_READY, capture P, G, CI, clear CO,
//      set index=0 and carry=CI, go to RUN.
//    - RUN: each cycle resolve bits [index, min(index+CHUNK, WIDTH)-1] from
//      the LSB up, rippling carry inside the chunk. Write CO for those bits,
//      store the top carry, advance index by CHUNK. When the last chunk is
//      done, go to DONE.
//    - DONE: OUT_VALID=1, CO held stable. On OUT_VALID&OUT_READY, go to
//      IDLE and drop OUT_VALID.
//  - RUN lasts NCH = ceil(WIDTH/CHUNK) cycles.
//  - Latency: the accept edge plus NCH edges; OUT_VALID is high in the
//    cycle after the last RUN edge.
//  - Partial last chunk (WIDTH % CHUNK != 0): only in-range bits are
//    evaluated. No out-of-range index into P/G/CO.
//  - The index counter is sized $clog2(WIDTH+CHUNK)+1 so it cannot wrap.
//  - IN_READY=0 outside IDLE: no overlap and no back-to-back accept. An
//    input held through DONE is accepted in the next IDLE cycle.
//  - IN_VALID in RUN/DONE is ignored; captured operands are not
//    disturbed.
//  - CO keeps its last resolved value after the DONE handshake until the
//    next accept clears it.
//  - X on P/G outside the accept cycle must not propagate.
// CONFIGURATION
//  LCU_SEQ_GROUP_EN defined:
//   - Adds outputs PO (1) = &P and GO (1) = CO[WIDTH-1] & ~(CI & PO), the
//     group generate independent of CI.
//   - PO is accumulated per chunk during RUN and is valid with OUT_VALID.
//   - Both outputs reset to 0.
//  LCU_SEQ_GROUP_EN undefined: ports PO/GO and their logic are absent;
//   the rest of the behaviour is identical.
// TESTING  (WIDTH=8, CHUNK=3 unless noted; NCH=3)
//  1. Reset, then idle: IN_READY=1, OUT_VALID=0, CO=8'h00. P=8'hFF, G=8'h00,
//     CI=1 accepted -> OUT_VALID 4 cycles later, CO=8'hFF.
//  2. P=8'hFE, G=8'h01, CI=0 -> CO=8'hFF. P=8'h00, G=8'h81, CI=1 ->
//     CO=8'h81.
//  3. OUT_READY held 0 for 5 cycles in DONE -> CO stable, IN_READY=0, a new
//     IN_VALID is not accepted. Release -> IDLE, then the new op is
//     accepted.
//  4. SRST pulsed on the second RUN cycle -> next cycle IDLE, CO=0,
//     OUT_VALID stays 0. A following op completes correctly.
//  5. WIDTH=5, CHUNK=5 (one chunk) and WIDTH=5, CHUNK=1 (5 chunks),
//     P=5'h1F, G=0, CI=1 -> CO=5'h1F after 1 and 5 RUN cycles.
//  6. LCU_SEQ_GROUP_EN: P=8'hFF, G=0, CI=1 -> PO=1, GO=0. P=8'h7F,
//     G=8'h80, CI=0 -> PO=0, GO=1.
//  Random P/G/CI checked against a combinational $lcu model.

Source files
------------

// File: rtl/lcu_seq_chunked_if.sv
// Handshake bundle for lcu_seq_chunked: operand side (p/g/ci) and carry-out side (co).
// PO/GO group outputs exist only when LCU_SEQ_GROUP_EN is defined.
interface lcu_seq_chunked_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] co;
`ifdef LCU_SEQ_GROUP_EN
  logic             po;
  logic             go;

  modport master (output in_valid, p, g, ci, out_ready,
                  input  in_ready, out_valid, co, po, go);
  modport slave  (input  in_valid, p, g, ci, out_ready,
                  output in_ready, out_valid, co, po, go);
`else
  modport master (output in_valid, p, g, ci, out_ready,
                  input  in_ready, out_valid, co);
  modport slave  (input  in_valid, p, g, ci, out_ready,
                  output in_ready, out_valid, co);
`endif
endinterface

// File: rtl/lcu_seq_chunked.sv
// Multi-cycle lookahead-carry unit resolving CO[i] = G[i] | (P[i] & CO[i-1]) CHUNK bits per clock.
// Optional group propagate/generate outputs (PO/GO) are enabled by LCU_SEQ_GROUP_EN.
module lcu_seq_chunked #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             srst,
  lcu_seq_chunked_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH + CHUNK) + 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] g_q;
  logic [WIDTH-1:0] co_q;

  logic [WIDTH-1:0] co_n;
  logic             carry_n;
  logic [IDX_W-1:0] bit_idx;
  logic             last_chunk;
`ifdef LCU_SEQ_GROUP_EN
  logic             ci_q;
  logic             po_acc;
  logic             po_n;
  logic             po_q;
  logic             go_q;
`endif

  // One chunk of the ripple, starting at idx; bits past WIDTH-1 are skipped
  always_comb begin
    co_n    = co_q;
    carry_n = carry;
    bit_idx = '0;
`ifdef LCU_SEQ_GROUP_EN
    po_n    = po_acc;
`endif
    for (int k = 0; k < CHUNK; k++) begin
      bit_idx = idx + IDX_W'(k);
      if (bit_idx < IDX_W'(WIDTH)) begin
        carry_n = g_q[bit_idx[BIT_W-1:0]] | (p_q[bit_idx[BIT_W-1:0]] & carry_n);
        co_n[bit_idx[BIT_W-1:0]] = carry_n;
`ifdef LCU_SEQ_GROUP_EN
        po_n = po_n & p_q[bit_idx[BIT_W-1:0]];
`endif
      end
    end
  end

  assign last_chunk = (idx + IDX_W'(CHUNK)) >= IDX_W'(WIDTH);

  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      co_q        <= '0;
      idx         <= '0;
      carry       <= 1'b0;
`ifdef LCU_SEQ_GROUP_EN
      po_acc      <= 1'b0;
      po_q        <= 1'b0;
      go_q        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            p_q        <= bus.p;
            g_q        <= bus.g;
            co_q       <= '0;
            idx        <= '0;
            carry      <= bus.ci;
            in_ready_q <= 1'b0;
            state      <= RUN;
`ifdef LCU_SEQ_GROUP_EN
            ci_q       <= bus.ci;
            po_acc     <= 1'b1;
            po_q       <= 1'b0;
            go_q       <= 1'b0;
`endif
          end
        end
        RUN: begin
          co_q  <= co_n;
          carry <= carry_n;
          idx   <= idx + IDX_W'(CHUNK);
`ifdef LCU_SEQ_GROUP_EN
          po_acc <= po_n;
`endif
          if (last_chunk) begin
            out_valid_q <= 1'b1;
            state       <= DONE;
`ifdef LCU_SEQ_GROUP_EN
            po_q <= po_n;
            go_q <= co_n[WIDTH-1] & ~(ci_q & po_n);
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.co        = co_q;
`ifdef LCU_SEQ_GROUP_EN
  assign bus.po        = po_q;
  assign bus.go        = go_q;
`endif
endmodule

// File: tb/tb_lcu_seq_chunked.sv
// Directed and random bench for lcu_seq_chunked (8/3 main instance, 5/5 and 5/1 side instances).
// Expected carries come from a "generate-then-unbroken-propagate" model of the carry chain.
module tb_lcu_seq_chunked;
  localparam int W   = 8;
  localparam int C   = 3;
  localparam int NCH = 3;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  lcu_seq_chunked_if #(.WIDTH(W)) bus ();
  lcu_seq_chunked_if #(.WIDTH(5)) bus_a ();
  lcu_seq_chunked_if #(.WIDTH(5)) bus_b ();

  lcu_seq_chunked #(.WIDTH(W), .CHUNK(C)) dut   (.clk(clk), .srst(srst), .bus(bus));
  lcu_seq_chunked #(.WIDTH(5), .CHUNK(5)) dut_a (.clk(clk), .srst(srst), .bus(bus_a));
  lcu_seq_chunked #(.WIDTH(5), .CHUNK(1)) dut_b (.clk(clk), .srst(srst), .bus(bus_b));

  int total = 0;
  int bad   = 0;

  // CO[i]=1 iff some G[j] (j<=i) is followed by all-ones P[j+1..i], or CI with all-ones P[0..i]
  function automatic logic [31:0] ref_co(int w, logic [31:0] p, logic [31:0] g, logic ci);
    logic [31:0] r;
    logic hit;
    logic run;
    r = '0;
    for (int i = 0; i < w; i++) begin
      hit = ci;
      for (int j = 0; j <= i; j++) if (!p[j]) hit = 1'b0;
      for (int j = 0; j <= i; j++) begin
        if (g[j]) begin
          run = 1'b1;
          for (int k = j + 1; k <= i; k++) if (!p[k]) run = 1'b0;
          if (run) hit = 1'b1;
        end
      end
      r[i] = hit;
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic do_op(logic [7:0] p, logic [7:0] g, logic ci, int hold);
    int n;
    logic [7:0] exp_co;
    exp_co = ref_co(W, {24'd0, p}, {24'd0, g}, ci);
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_idle", bus.in_ready, 1);
    bus.p = p; bus.g = g; bus.ci = ci; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.p = 8'($urandom); bus.g = 8'($urandom); bus.ci = 1'($urandom);
    chk("in_ready_busy", bus.in_ready, 0);
    wait_done(n);
    chk("latency", n, NCH);
    chk("co", bus.co, exp_co);
`ifdef LCU_SEQ_GROUP_EN
    chk("po", bus.po, &p);
    chk("go", bus.go, exp_co[7] & ~(ci & (&p)));
`endif
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("co_hold", bus.co, exp_co);
      chk("out_valid_hold", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("out_valid_drop", bus.out_valid, 0);
    chk("in_ready_back", bus.in_ready, 1);
    chk("co_kept", bus.co, exp_co);
  endtask

  initial begin
    int n, na, nb;
    logic [7:0] bp, bg;
    logic bci;

    srst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.p = '0; bus.g = '0; bus.ci = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0; bus_a.p = '0; bus_a.g = '0; bus_a.ci = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0; bus_b.p = '0; bus_b.g = '0; bus_b.ci = 1'b0;
    tick();
    tick();
    srst = 1'b0;
    tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_co", bus.co, 0);

    do_op(8'hFF, 8'h00, 1'b1, 0);
    do_op(8'hFE, 8'h01, 1'b0, 1);
    do_op(8'h00, 8'h81, 1'b1, 0);
    do_op(8'h7F, 8'h80, 1'b0, 0);
    chk("const_co_81", ref_co(W, 32'h00, 32'h81, 1'b1), 32'h81);

    // Stall in DONE with a new request pending
    bus.p = 8'h3C; bus.g = 8'hC3; bus.ci = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_done(n);
    chk("stall_latency", n, NCH);
    bp = 8'($urandom); bg = 8'($urandom); bci = 1'($urandom);
    bus.p = bp; bus.g = bg; bus.ci = bci; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_co", bus.co, ref_co(W, 32'h3C, 32'hC3, 1'b1));
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_out_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("release_in_ready", bus.in_ready, 1);
    chk("release_out_valid", bus.out_valid, 0);
    tick();
    bus.in_valid = 1'b0;
    chk("pending_accepted", bus.in_ready, 0);
    wait_done(n);
    chk("pending_latency", n, NCH);
    chk("pending_co", bus.co, ref_co(W, {24'd0, bp}, {24'd0, bg}, bci));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset during the second RUN cycle
    bus.p = 8'hFF; bus.g = 8'h00; bus.ci = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_co", bus.co, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_valid", bus.out_valid, 0);
    end
    do_op(8'($urandom), 8'($urandom), 1'($urandom), 0);

    // Single-chunk and one-bit-per-cycle instances side by side
    bus_a.p = 5'h1F; bus_a.g = 5'h00; bus_a.ci = 1'b1; bus_a.in_valid = 1'b1;
    bus_b.p = 5'h1F; bus_b.g = 5'h00; bus_b.ci = 1'b1; bus_b.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0;
    na = -1; nb = -1;
    for (int i = 0; i < 12; i++) begin
      if (bus_a.out_valid && na < 0) na = i;
      if (bus_b.out_valid && nb < 0) nb = i;
      tick();
    end
    chk("w5c5_latency", na, 1);
    chk("w5c1_latency", nb, 5);
    chk("w5c5_co", bus_a.co, 5'h1F);
    chk("w5c1_co", bus_b.co, 5'h1F);
    bus_a.out_ready = 1'b1; bus_b.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0; bus_b.out_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      bp = 8'($urandom); bg = 8'($urandom); bci = 1'($urandom);
      bus_a.p = bp[4:0]; bus_a.g = bg[4:0]; bus_a.ci = bci; bus_a.in_valid = 1'b1;
      bus_b.p = bp[4:0]; bus_b.g = bg[4:0]; bus_b.ci = bci; bus_b.in_valid = 1'b1;
      tick();
      bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0;
      repeat (6) tick();
      chk("w5c5_rand_co", bus_a.co, ref_co(5, {27'd0, bp[4:0]}, {27'd0, bg[4:0]}, bci));
      chk("w5c1_rand_co", bus_b.co, ref_co(5, {27'd0, bp[4:0]}, {27'd0, bg[4:0]}, bci));
      bus_a.out_ready = 1'b1; bus_b.out_ready = 1'b1;
      tick();
      bus_a.out_ready = 1'b0; bus_b.out_ready = 1'b0;
    end

    // Random operations on the main instance
    for (int t = 0; t < 30; t++) begin
      bp = 8'($urandom);
      bg = 8'($urandom) & 8'($urandom);
      if (t % 4 == 0) bp = 8'hFF;
      do_op(bp, bg, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
